// File: rtl/tx_preamble_gen.sv
// 802.11a preamble sample source: STS periods, LTS guard interval, LTS symbols.
// Samples are streamed over a valid/ready handshake with registered outputs.
// Optional boundary windowing is enabled by defining TX_PREAMBLE_WINDOW_EN.
module tx_preamble_gen #(
  parameter int unsigned STS_REPEAT = 10,
  parameter int unsigned LTS_REPEAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               start,
  output logic signed [15:0] sample_out_i,
  output logic signed [15:0] sample_out_q,
  output logic               sample_out_valid,
  input  logic               sample_out_ready,
  output logic               preamble_busy,
  output logic               preamble_done
);

  localparam int unsigned STS_LEN = 16 * STS_REPEAT;
  localparam int unsigned GI_LEN  = 32;
  localparam int unsigned LTS_LEN = 64 * LTS_REPEAT;
  localparam int unsigned CNT_MAX = (STS_LEN > LTS_LEN) ? STS_LEN : LTS_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, STS, LTS_GI, LTS, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [31:0]        smp_q, smp_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               accept;

  // Pack one I/Q pair given in thousandths of full scale (x100 -> peak 16100).
  function automatic logic [31:0] iq(input int re, input int im);
    return {16'(re * 100), 16'(im * 100)};
  endfunction

  // Time-domain short training sequence, one 16-sample period.
  function automatic logic [31:0] sts_rom(input logic [3:0] a);
    logic [31:0] r;
    case (a)
      4'd0:  r = iq(  46,   46);  4'd1:  r = iq(-132,    2);
      4'd2:  r = iq( -13,  -79);  4'd3:  r = iq( 143,  -13);
      4'd4:  r = iq(  92,    0);  4'd5:  r = iq( 143,  -13);
      4'd6:  r = iq( -13,  -79);  4'd7:  r = iq(-132,    2);
      4'd8:  r = iq(  46,   46);  4'd9:  r = iq(   2, -132);
      4'd10: r = iq( -79,  -13);  4'd11: r = iq( -13,  143);
      4'd12: r = iq(   0,   92);  4'd13: r = iq( -13,  143);
      4'd14: r = iq( -79,  -13);  default: r = iq(2, -132);
    endcase
    return r;
  endfunction

  // Time-domain long training symbol, 64 samples.
  function automatic logic [31:0] lts_rom(input logic [5:0] a);
    logic [31:0] r;
    case (a)
      6'd0:  r = iq( 156,    0);  6'd1:  r = iq(  -5, -120);  6'd2:  r = iq(  40, -111);  6'd3:  r = iq(  97,   83);
      6'd4:  r = iq(  21,   28);  6'd5:  r = iq(  60,  -88);  6'd6:  r = iq(-115,  -55);  6'd7:  r = iq( -38, -106);
      6'd8:  r = iq(  98,  -26);  6'd9:  r = iq(  53,    4);  6'd10: r = iq(   1, -115);  6'd11: r = iq(-137,  -47);
      6'd12: r = iq(  24,  -59);  6'd13: r = iq(  59,  -15);  6'd14: r = iq( -22,  161);  6'd15: r = iq( 119,   -4);
      6'd16: r = iq(  62,  -62);  6'd17: r = iq(  37,   98);  6'd18: r = iq( -57,   39);  6'd19: r = iq(-131,   65);
      6'd20: r = iq(  82,   92);  6'd21: r = iq(  70,   14);  6'd22: r = iq( -60,   81);  6'd23: r = iq( -56,  -22);
      6'd24: r = iq( -35, -151);  6'd25: r = iq(-122,  -17);  6'd26: r = iq(-127,  -21);  6'd27: r = iq(  75,  -74);
      6'd28: r = iq(  -3,   54);  6'd29: r = iq( -92,  115);  6'd30: r = iq(  92,  106);  6'd31: r = iq(  12,   98);
      6'd32: r = iq(-156,    0);  6'd33: r = iq(  12,  -98);  6'd34: r = iq(  92, -106);  6'd35: r = iq( -92, -115);
      6'd36: r = iq(  -3,  -54);  6'd37: r = iq(  75,   74);  6'd38: r = iq(-127,   21);  6'd39: r = iq(-122,   17);
      6'd40: r = iq( -35,  151);  6'd41: r = iq( -56,   22);  6'd42: r = iq( -60,  -81);  6'd43: r = iq(  70,  -14);
      6'd44: r = iq(  82,  -92);  6'd45: r = iq(-131,  -65);  6'd46: r = iq( -57,  -39);  6'd47: r = iq(  37,  -98);
      6'd48: r = iq(  62,   62);  6'd49: r = iq( 119,    4);  6'd50: r = iq( -22, -161);  6'd51: r = iq(  59,   15);
      6'd52: r = iq(  24,   59);  6'd53: r = iq(-137,   47);  6'd54: r = iq(   1,  115);  6'd55: r = iq(  53,   -4);
      6'd56: r = iq(  98,   26);  6'd57: r = iq( -38,  106);  6'd58: r = iq(-115,   55);  6'd59: r = iq(  60,   88);
      6'd60: r = iq(  21,  -28);  6'd61: r = iq(  97,  -83);  6'd62: r = iq(  40,  111);  default: r = iq(-5, 120);
    endcase
    return r;
  endfunction

  // Boundary window: halve the first sample of the STS and of the LTS guard.
  function automatic logic [31:0] win(input logic [31:0] s);
`ifdef TX_PREAMBLE_WINDOW_EN
    logic signed [15:0] wi;
    logic signed [15:0] wq;
    wi = $signed(s[31:16]) >>> 1;
    wq = $signed(s[15:0]) >>> 1;
    return {wi, wq};
`else
    return s;
`endif
  endfunction

  // Next-state, next-sample and handshake logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);
    accept  = valid_q && sample_out_ready;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STS;
          cnt_d   = '0;
          smp_d   = win(sts_rom(4'd0));
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      STS: begin
        if (accept) begin
          if (cnt_q == CNT_W'(STS_LEN - 1)) begin
            state_d = LTS_GI;
            cnt_d   = '0;
            smp_d   = win(lts_rom(6'd32));
          end else begin
            cnt_d = cnt_inc;
            smp_d = sts_rom(cnt_inc[3:0]);
          end
        end
      end
      LTS_GI: begin
        if (accept) begin
          if (cnt_q == CNT_W'(GI_LEN - 1)) begin
            state_d = LTS;
            cnt_d   = '0;
            smp_d   = lts_rom(6'd0);
          end else begin
            cnt_d = cnt_inc;
            smp_d = lts_rom({1'b1, cnt_inc[4:0]});
          end
        end
      end
      LTS: begin
        if (accept) begin
          if (cnt_q == CNT_W'(LTS_LEN - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            smp_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            smp_d = lts_rom(cnt_inc[5:0]);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Losing enable abandons the preamble silently.
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      smp_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      smp_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sample_out_i     = smp_q[31:16];
  assign sample_out_q     = smp_q[15:0];
  assign sample_out_valid = valid_q;
  assign preamble_busy    = busy_q;
  assign preamble_done    = done_q;

endmodule

// File: tb/tb_tx_preamble_gen.sv
// Directed bench for tx_preamble_gen at default parameters.
module tb_tx_preamble_gen;

  localparam int unsigned N_SAMP = 320;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               start;
  logic               ready;
  logic signed [15:0] out_i;
  logic signed [15:0] out_q;
  logic               out_valid;
  logic               busy;
  logic               done;

  always #5 clk = ~clk;

  tx_preamble_gen dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .start            (start),
    .sample_out_i     (out_i),
    .sample_out_q     (out_q),
    .sample_out_valid (out_valid),
    .sample_out_ready (ready),
    .preamble_busy    (busy),
    .preamble_done    (done)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // 802.11a reference sequences in thousandths of full scale.
  int sts_re[16] = '{46, -132, -13, 143, 92, 143, -13, -132, 46, 2, -79, -13, 0, -13, -79, 2};
  int sts_im[16] = '{46, 2, -79, -13, 0, -13, -79, 2, 46, -132, -13, 143, 92, 143, -13, -132};
  int lts_re[64] = '{156, -5, 40, 97, 21, 60, -115, -38, 98, 53, 1, -137, 24, 59, -22, 119,
                     62, 37, -57, -131, 82, 70, -60, -56, -35, -122, -127, 75, -3, -92, 92, 12,
                     -156, 12, 92, -92, -3, 75, -127, -122, -35, -56, -60, 70, 82, -131, -57, 37,
                     62, 119, -22, 59, 24, -137, 1, 53, 98, -38, -115, 60, 21, 97, 40, -5};
  int lts_im[64] = '{0, -120, -111, 83, 28, -88, -55, -106, -26, 4, -115, -47, -59, -15, 161, -4,
                     -62, 98, 39, 65, 92, 14, 81, -22, -151, -17, -21, -74, 54, 115, 106, 98,
                     0, -98, -106, -115, -54, 74, 21, 17, 151, 22, -81, -14, -92, -65, -39, -98,
                     62, 4, -161, 15, 59, 47, 115, -4, 26, 106, 55, 88, -28, -83, 111, 120};

  logic [31:0] exp_s[N_SAMP];
  logic [31:0] acc_q[$];
  int          done_cnt;
  int          done_cyc;
  int          last_acc_cyc;
  int          first_valid_cyc;

  function automatic logic [31:0] mk(input int re, input int im);
    return {16'(re * 100), 16'(im * 100)};
  endfunction

  function automatic logic [31:0] half(input logic [31:0] s);
    logic signed [15:0] a;
    logic signed [15:0] b;
    a = s[31:16];
    b = s[15:0];
    a = a >>> 1;
    b = b >>> 1;
    return {a, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One preamble: optional ready toggling, second start, start-in-DONE, abort.
  task automatic run_preamble(input string name, input bit toggle, input int restart_at,
                              input bit start_in_done, input int abort_at, input bit abort_rst);
    int          n = 0;
    bit          restarted = 1'b0;
    bit          prev_hold = 1'b0;
    bit          aborted = 1'b0;
    logic [31:0] prev_s = '0;
    acc_q.delete();
    done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; first_valid_cyc = -1;
    @(negedge clk); start = 1'b1; ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (start) start = 1'b0;
      if (done_cnt > 0 && cyc > done_cyc)
        check($sformatf("%s valid idle after done c%0d", name, cyc), 32'(out_valid), 32'(0));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check($sformatf("%s busy at done", name), 32'(busy), 32'(0));
        check($sformatf("%s valid at done", name), 32'(out_valid), 32'(0));
        if (start_in_done) start = 1'b1;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_hold) begin
        check($sformatf("%s hold data c%0d", name, cyc), {out_i, out_q}, prev_s);
        check($sformatf("%s hold valid c%0d", name, cyc), 32'(out_valid), 32'(1));
      end
      prev_hold = out_valid && !ready;
      prev_s    = {out_i, out_q};
      if (abort_at >= 0 && n == abort_at) begin
        if (abort_rst) rst = 1'b1;
        else enable = 1'b0;
        aborted = 1'b1;
        break;
      end
      if (restart_at >= 0 && n == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (out_valid && ready) begin
        acc_q.push_back({out_i, out_q});
        n++;
        last_acc_cyc = cyc;
      end
      if (done_cnt > 0 && cyc > done_cyc + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
    if (aborted) begin
      @(negedge clk);
      check($sformatf("%s abort valid", name), 32'(out_valid), 32'(0));
      check($sformatf("%s abort busy", name), 32'(busy), 32'(0));
      check($sformatf("%s abort done", name), 32'(done), 32'(0));
      rst = 1'b0; enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (done) done_cnt++;
      end
      check($sformatf("%s abort no done pulse", name), 32'(done_cnt), 32'(0));
      check($sformatf("%s abort sample count", name), 32'(acc_q.size()), 32'(abort_at));
    end else begin
      check($sformatf("%s sample count", name), 32'(acc_q.size()), 32'(N_SAMP));
      check($sformatf("%s done count", name), 32'(done_cnt), 32'(1));
      check($sformatf("%s done timing", name), 32'(done_cyc), 32'(last_acc_cyc + 1));
      check($sformatf("%s first valid latency", name), 32'(first_valid_cyc), 32'(0));
      if (!toggle)
        check($sformatf("%s no bubbles", name), 32'(last_acc_cyc), 32'(N_SAMP - 1));
    end
    for (int i = 0; i < acc_q.size() && i < int'(N_SAMP); i++)
      check($sformatf("%s s%0d", name, i), acc_q[i], exp_s[i]);
  endtask

  initial begin
    for (int n = 0; n < int'(N_SAMP); n++) begin
      if (n < 160)      exp_s[n] = mk(sts_re[n % 16], sts_im[n % 16]);
      else if (n < 192) exp_s[n] = mk(lts_re[32 + n - 160], lts_im[32 + n - 160]);
      else              exp_s[n] = mk(lts_re[(n - 192) % 64], lts_im[(n - 192) % 64]);
    end
`ifdef TX_PREAMBLE_WINDOW_EN
    exp_s[0]   = half(exp_s[0]);
    exp_s[160] = half(exp_s[160]);
`endif

    rst = 1'b1; enable = 1'b1; start = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset i", 32'(out_i), 32'(0));
    check("reset q", 32'(out_q), 32'(0));
    check("reset valid", 32'(out_valid), 32'(0));
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // start while disabled has no effect
    enable = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("disabled start valid", 32'(out_valid), 32'(0));
    check("disabled start busy", 32'(busy), 32'(0));
    enable = 1'b1;
    @(negedge clk);

    run_preamble("ready_high", 1'b0, -1, 1'b0, -1, 1'b0);
    if (acc_q.size() == N_SAMP) begin
      check("sts period repeat", acc_q[16], mk(sts_re[0], sts_im[0]));
      check("gi tail at 224", acc_q[224], mk(lts_re[32], lts_im[32]));
      check("lts start at 192", acc_q[192], mk(lts_re[0], lts_im[0]));
      check("lts repeat at 256", acc_q[256], mk(lts_re[0], lts_im[0]));
    end else begin
      check("ready_high length for relations", 32'(acc_q.size()), 32'(N_SAMP));
    end

    run_preamble("ready_toggle", 1'b1, -1, 1'b0, -1, 1'b0);
    run_preamble("restart_50", 1'b0, 50, 1'b1, -1, 1'b0);
    run_preamble("enable_abort", 1'b0, -1, 1'b0, 100, 1'b0);
    run_preamble("after_abort", 1'b0, -1, 1'b0, -1, 1'b0);
    run_preamble("reset_abort", 1'b1, -1, 1'b0, 37, 1'b1);
    run_preamble("after_reset", 1'b0, -1, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tx_preamble_gen.md
TX_PREAMBLE_GEN -- requirements
Module: tx_preamble_gen

Interface
REQ-001 The block SHALL have one parameter: STS_REPEAT, default 10, number of 16-sample short training periods emitted.
REQ-002 The block SHALL have one parameter: LTS_REPEAT, default 2, number of 64-sample long training symbols emitted after the 32-sample LTS guard interval.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  block enable; low forces abort to IDLE.
REQ-007 start  input  1  single-cycle request to emit one preamble.
REQ-008 sample_out_i  output  16  signed in-phase preamble sample.
REQ-009 sample_out_q  output  16  signed quadrature preamble sample.
REQ-010 sample_out_valid  output  1  sample_out_i/q hold a valid sample.
REQ-011 sample_out_ready  input  1  downstream accepts the sample when high together with valid.
REQ-012 preamble_busy  output  1  high from start acceptance until the last sample is accepted.
REQ-013 preamble_done  output  1  one-cycle pulse after the last sample is accepted.

Function
REQ-014 The block SHALL contain a 16-entry STS ROM and a 64-entry LTS ROM of signed 16-bit I/Q: IEEE 802.11a time-domain STS and LTS, amplitude scaled so the peak |I| and |Q| are each at most 16383.
REQ-015 State machine states SHALL be IDLE, STS, LTS_GI, LTS, DONE.
REQ-016 In IDLE with enable high, start high SHALL move the FSM to STS; sample index n = 0; valid asserts with sample 0 on the next cycle (1-cycle latency).
REQ-017 STS state SHALL output STS_ROM[n mod 16] for n = 0 .. 16*STS_REPEAT-1.
REQ-018 LTS_GI state SHALL output LTS_ROM[32+k] for k = 0..31.
REQ-019 LTS state SHALL output LTS_ROM[m mod 64] for m = 0 .. 64*LTS_REPEAT-1.
REQ-020 The sample index SHALL advance only on a cycle where valid and ready are both high; otherwise data and valid SHALL hold unchanged.
REQ-021 Acceptance of the last LTS sample SHALL move the FSM to DONE; the next cycle preamble_done pulses, valid drops, busy drops, and the FSM returns to IDLE.
REQ-022 Total samples per preamble SHALL be 16*STS_REPEAT + 32 + 64*LTS_REPEAT (320 at default).
REQ-023 start while busy SHALL be ignored; start coincident with a DONE-state cycle SHALL be ignored.
REQ-024 enable low in any state SHALL return the FSM to IDLE on the next cycle with valid, busy and done low; no done pulse for an aborted preamble.
REQ-025 Continuous ready high SHALL yield one sample per clock with no bubbles across state boundaries.

Reset
REQ-026 rst high SHALL force IDLE; sample_out_i, sample_out_q, sample_out_valid, preamble_busy and preamble_done SHALL be 0 on the following cycle.
REQ-027 rst mid-preamble SHALL discard the remaining samples without a done pulse.

Configuration
REQ-028 Macro TX_PREAMBLE_WINDOW_EN defined: sample n = 0 and the first LTS_GI sample SHALL be output arithmetic-shifted right by 1 (I and Q) for boundary windowing.
REQ-029 Macro TX_PREAMBLE_WINDOW_EN undefined: all samples SHALL be raw ROM values; the interface is unchanged.

Verification
REQ-030 Start with ready held high, defaults -> 320 consecutive valid cycles starting 1 cycle after start; done pulses once, 1 cycle after the 320th sample.
REQ-031 Default run -> output[16] == output[0]; output[160] == output[224] == LTS_ROM[32]; output[192] == output[256] == LTS_ROM[0].
REQ-032 ready toggled 1/0 every cycle -> identical 320-sample sequence; data stable while ready is low; done only after 320 acceptances.
REQ-033 Second start pulse at sample 50 -> ignored; exactly 320 samples and one done.
REQ-034 enable dropped at sample 100 -> valid/busy low the next cycle, no done; a fresh start restarts at STS_ROM[0].
REQ-035 TX_PREAMBLE_WINDOW_EN defined -> output[0] == STS_ROM[0]>>>1 and output[160] == LTS_ROM[32]>>>1; all other samples equal the undefined build.
